// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared state type and index helpers for the scan word selector
package scan_mux_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_EMIT} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int phys_idx(input int k, input int n, input bit rev);
    return rev ? n - 1 - k : k;
  endfunction
endpackage

// File: rtl/ch_next_find.sv
// ch_next_find: rotating priority encoder returning the first set mask bit at or after start
module ch_next_find #(
  parameter int N_CH = 16,
  parameter int SEL_W = 4
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  // Walk offsets from farthest to nearest so the nearest enabled channel is written last
  always_comb begin
    idx = '0;
    found = |mask;
    for (int i = N_CH - 1; i >= 0; i--)
      if (mask[(int'(start) + i) % N_CH]) idx = SEL_W'((int'(start) + i) % N_CH);
  end
endmodule

// File: rtl/scan_mux_sel.sv
// scan_mux_sel: registered N-channel word selector with manual and round-robin scan modes
module scan_mux_sel
  import scan_mux_pkg::*;
#(
  parameter int N_CH = 16,
  parameter int DW = 8,
  parameter int DWELL = 4,
  parameter bit REVERSE = 1'b0,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*DW-1:0] d,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_load,
  input  logic [N_CH-1:0]   en_mask,
  input  logic              out_ready,
  output logic [DW-1:0]     y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_valid,
  output logic              err
);
  state_t state, nstate;
  logic [7:0] cnt;
  logic [SEL_W-1:0] cur, ptr, nidx, phys;
  logic [N_CH-1:0] lmask;
  logic found, load_ok, load_bad, fire;

  ch_next_find #(.N_CH(N_CH), .SEL_W(SEL_W)) u_find (
    .mask(lmask),
    .start(ptr),
    .idx(nidx),
    .found(found)
  );

  assign phys = SEL_W'(phys_idx(int'(cur), N_CH, REVERSE));
  assign load_ok = state == ST_IDLE && !mode && sel_load && int'(sel) < N_CH;
  assign load_bad = state == ST_IDLE && !mode && sel_load && int'(sel) >= N_CH;
  assign fire = state == ST_EMIT && (!y_valid || out_ready);

  // Present en_mask in logical order so the finder walks the (possibly reversed) scan order
  always_comb begin
    lmask = '0;
    for (int k = 0; k < N_CH; k++) lmask[k] = en_mask[phys_idx(k, N_CH, REVERSE)];
  end

  // Next-state selection; a dropped mode aborts a dwell before it can emit
  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE:  nstate = load_ok ? ST_EMIT : (mode && found) ? ST_DWELL : ST_IDLE;
      ST_DWELL: nstate = !mode ? ST_IDLE : (cnt == 8'(DWELL - 1)) ? ST_EMIT : ST_DWELL;
      ST_EMIT:  nstate = fire ? ST_IDLE : ST_EMIT;
      default:  nstate = ST_IDLE;
    endcase
  end

  // State, dwell counter, channel pointers and the held output slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      cur <= '0;
      ptr <= '0;
      y <= '0;
      y_ch <= '0;
      y_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nstate;
      cnt <= (state == ST_DWELL && nstate == ST_DWELL) ? cnt + 8'd1 : 8'd0;
      err <= load_bad;
      if (load_ok) cur <= sel;
      else if (state == ST_IDLE && mode && found) cur <= nidx;
      if (fire && mode) ptr <= (int'(cur) == N_CH - 1) ? '0 : cur + 1'b1;
      if (fire) begin
        y <= d[phys*DW +: DW];
        y_ch <= phys;
      end
      y_valid <= fire | (y_valid & ~out_ready);
    end
  end
endmodule

// File: tb/tb_scan_mux_sel.sv
// tb_scan_mux_sel: scoreboard bench for manual, scan, backpressure and boundary behaviour
module tb_scan_mux_sel;
  localparam int DW = 8;
  typedef struct packed {logic [3:0] ch; logic [7:0] w;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [16*DW-1:0] d;
  logic [12*DW-1:0] d12;
  logic mode = 1'b0, sel_load = 1'b0, out_ready = 1'b1;
  logic [3:0] sel = '0;
  logic [15:0] en_mask = '0;
  logic [7:0] y, y_r, y_s;
  logic [3:0] y_ch, y_ch_r, y_ch_s;
  logic y_valid, y_valid_r, y_valid_s, err, err_r, err_s;
  int n_chk = 0, n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  scan_mux_sel #(.N_CH(16), .DW(DW), .DWELL(4), .REVERSE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel(sel), .sel_load(sel_load),
    .en_mask(en_mask), .out_ready(out_ready), .y(y), .y_ch(y_ch), .y_valid(y_valid), .err(err));
  scan_mux_sel #(.N_CH(16), .DW(DW), .DWELL(4), .REVERSE(1'b1)) dut_r (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel(sel), .sel_load(sel_load),
    .en_mask(en_mask), .out_ready(out_ready), .y(y_r), .y_ch(y_ch_r), .y_valid(y_valid_r), .err(err_r));
  scan_mux_sel #(.N_CH(12), .DW(DW), .DWELL(4), .REVERSE(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .d(d12), .mode(mode), .sel(sel), .sel_load(sel_load),
    .en_mask(en_mask[11:0]), .out_ready(out_ready), .y(y_s), .y_ch(y_ch_s), .y_valid(y_valid_s), .err(err_s));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    mode = 1'b0;
    sel_load = 1'b0;
    out_ready = 1'b1;
    en_mask = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({y, y_ch, y_valid, err} !== '0) begin n_fail++; $display("FAIL reset_outputs: got y=%h ch=%0d v=%b err=%b want all zero", y, y_ch, y_valid, err); end
    rst_n = 1'b1;
  endtask

  task automatic test_manual;
    exp_t e;
    do_reset();
    sel = 4'd5;
    sel_load = 1'b1;
    sb.push_back('{4'd5, 8'h15});
    tick();
    sel_load = 1'b0;
    n_chk++;
    if (y_valid !== 1'b0) begin n_fail++; $display("FAIL manual_latency_early: got y_valid=%b want 0", y_valid); end
    tick();
    n_chk++;
    if (y_valid !== 1'b1) begin n_fail++; $display("FAIL manual_latency: got y_valid=%b want 1", y_valid); end
    e = sb.pop_front();
    n_chk++;
    if (y !== e.w || y_ch !== e.ch) begin n_fail++; $display("FAIL manual_word: got ch%0d %h want ch%0d %h", y_ch, y, e.ch, e.w); end
    n_chk++;
    if (y_r !== 8'h1A || y_ch_r !== 4'd10) begin n_fail++; $display("FAIL manual_reverse: got ch%0d %h want ch10 1a", y_ch_r, y_r); end
    n_chk++;
    if (y_s !== 8'h15 || y_ch_s !== 4'd5) begin n_fail++; $display("FAIL manual_n12: got ch%0d %h want ch5 15", y_ch_s, y_s); end
    tick();
    n_chk++;
    if (y_valid !== 1'b0) begin n_fail++; $display("FAIL manual_consume: got y_valid=%b want 0", y_valid); end
  endtask

  task automatic test_err;
    do_reset();
    sel = 4'd13;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    n_chk++;
    if (err_s !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got err_s=%b err=%b want 1 0", err_s, err); end
    tick();
    n_chk++;
    if (err_s !== 1'b0) begin n_fail++; $display("FAIL err_width: got err_s=%b want 0", err_s); end
    tick();
    tick();
    n_chk++;
    if (y_valid_s !== 1'b0) begin n_fail++; $display("FAIL err_no_sample: got y_valid_s=%b want 0", y_valid_s); end
  endtask

  task automatic test_scan;
    exp_t e;
    int last = -1, cyc = 0;
    do_reset();
    en_mask = 16'h0111;
    mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{4'd0, 8'h10});
      sb.push_back('{4'd4, 8'h14});
      sb.push_back('{4'd8, 8'h18});
    end
    while (sb.size() > 0 && cyc < 100) begin
      tick();
      cyc++;
      if (y_valid) begin
        e = sb.pop_front();
        n_chk++;
        if (y_ch !== e.ch || y !== e.w) begin n_fail++; $display("FAIL scan_word: got ch%0d %h want ch%0d %h", y_ch, y, e.ch, e.w); end
        if (last >= 0) begin
          n_chk++;
          if (cyc - last != 6) begin n_fail++; $display("FAIL scan_spacing: got %0d want 6", cyc - last); end
        end
        last = cyc;
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scan_timeout: got %0d samples missing want 0", sb.size()); sb.delete(); end
    mode = 1'b0;
  endtask

  task automatic test_backpressure;
    exp_t e;
    int cyc = 0;
    do_reset();
    out_ready = 1'b0;
    en_mask = 16'h0111;
    mode = 1'b1;
    sb.push_back('{4'd0, 8'h10});
    while (!y_valid && cyc < 20) begin tick(); cyc++; end
    n_chk++;
    if (y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got y_valid=%b want 1", y_valid); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 10) begin
        d[4*DW +: DW] = 8'hA4;
        sb.push_back('{4'd4, 8'hA4});
        sb.push_back('{4'd8, 8'h18});
      end
      n_chk++;
      if (y_valid !== 1'b1 || y !== sb[0].w || y_ch !== sb[0].ch) begin n_fail++; $display("FAIL bp_hold: got ch%0d %h v=%b want ch%0d %h v=1", y_ch, y, y_valid, sb[0].ch, sb[0].w); end
    end
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 40) begin
      if (y_valid) begin
        e = sb.pop_front();
        n_chk++;
        if (y_ch !== e.ch || y !== e.w) begin n_fail++; $display("FAIL bp_release: got ch%0d %h want ch%0d %h", y_ch, y, e.ch, e.w); end
      end
      tick();
      cyc++;
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d samples missing want 0", sb.size()); sb.delete(); end
    d[4*DW +: DW] = 8'h14;
    mode = 1'b0;
  endtask

  task automatic test_empty_mask;
    logic seen = 1'b0;
    do_reset();
    en_mask = '0;
    mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen |= y_valid;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL empty_mask: got y_valid seen=%b want 0", seen); end
    mode = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    int last = -1, cyc = 0;
    do_reset();
    en_mask = 16'h8000;
    mode = 1'b1;
    for (int r = 0; r < 3; r++) sb.push_back('{4'd15, 8'h1F});
    while (sb.size() > 0 && cyc < 60) begin
      tick();
      cyc++;
      if (y_valid) begin
        e = sb.pop_front();
        n_chk++;
        if (y_ch !== e.ch || y !== e.w) begin n_fail++; $display("FAIL single_word: got ch%0d %h want ch%0d %h", y_ch, y, e.ch, e.w); end
        if (last >= 0) begin
          n_chk++;
          if (cyc - last != 6) begin n_fail++; $display("FAIL single_spacing: got %0d want 6", cyc - last); end
        end
        last = cyc;
      end
    end
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL single_timeout: got %0d samples missing want 0", sb.size()); sb.delete(); end
    mode = 1'b0;
  endtask

  task automatic test_mode_drop;
    exp_t e;
    logic seen = 1'b0;
    int cyc = 0;
    do_reset();
    en_mask = 16'h0111;
    mode = 1'b1;
    tick();
    tick();
    tick();
    mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= y_valid;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mode_drop: got y_valid seen=%b want 0", seen); end
    mode = 1'b1;
    sb.push_back('{4'd0, 8'h10});
    while (!y_valid && cyc < 20) begin tick(); cyc++; end
    e = sb.pop_front();
    n_chk++;
    if (y_valid !== 1'b1 || y_ch !== e.ch || y !== e.w || cyc != 6) begin n_fail++; $display("FAIL mode_resume: got ch%0d %h v=%b after %0d want ch%0d %h v=1 after 6", y_ch, y, y_valid, cyc, e.ch, e.w); end
    mode = 1'b0;
  endtask

  task automatic test_reset_stall;
    logic seen = 1'b0;
    do_reset();
    out_ready = 1'b0;
    sel = 4'd3;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    sel = 4'd7;
    sel_load = 1'b1;
    tick();
    sel_load = 1'b0;
    tick();
    n_chk++;
    if (y_valid !== 1'b1 || y_ch !== 4'd3 || y !== 8'h13) begin n_fail++; $display("FAIL stall_hold: got ch%0d %h v=%b want ch3 13 v=1", y_ch, y, y_valid); end
    rst_n = 1'b0;
    tick();
    n_chk++;
    if ({y, y_ch, y_valid, err} !== '0) begin n_fail++; $display("FAIL stall_reset: got y=%h ch=%0d v=%b err=%b want all zero", y, y_ch, y_valid, err); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= y_valid;
    end
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL stall_discard: got y_valid seen=%b want 0", seen); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) d[k*DW +: DW] = 8'h10 + 8'(k);
    for (int k = 0; k < 12; k++) d12[k*DW +: DW] = 8'h10 + 8'(k);
    test_reset();
    test_manual();
    test_err();
    test_scan();
    test_backpressure();
    test_empty_mask();
    test_single();
    test_mode_drop();
    test_reset_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
